cacheline_adapter: RTL and testbench

Converts the single 256-bit cacheline request from the cache arbiter into a fixed-length burst of 64-bit beats on the physical memory port, and back again. Sits between the arbiter's adapter-side interface and burst memory. It holds one outstanding request at a time: it gathers read beats into a line buffer and serialises a latched write line into beats. It reports completion to the arbiter with a one-cycle `resp` pulse.

---
 rtl/cacheline_adapter_if.sv | 48 ++++
 rtl/cacheline_adapter.sv | 129 ++++++++++++
 tb/tb_cacheline_adapter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/cacheline_adapter_if.sv
`default_nettype none
// ============================================================================
// Module      : cacheline_adapter_if
// Description : Signal bundle for cacheline_adapter. It carries the
//               arbiter-side line request/response signals and the
//               memory-side burst signals.
//               slave  : the adapter's view. It takes line requests and
//                        drives the burst.
//               master : the environment's view. This is the arbiter and
//                        the burst memory together.
// Ports (slave view):
//   addr, read, write, wdata   in   line request from the arbiter
//   rdata, resp                out  assembled line / completion pulse
//   mem_addr, mem_read,
//   mem_write, mem_wdata       out  burst request to memory
//   mem_rdata, mem_resp        in   beat data / beat handshake from memory
// Revision    : 1.0 - initial release
// ============================================================================
interface cacheline_adapter_if #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
);
  // Arbiter side
  logic [31:0]       addr;
  logic              read;
  logic              write;
  logic [LINE_W-1:0] wdata;
  logic [LINE_W-1:0] rdata;
  logic              resp;
  // Memory side
  logic [31:0]       mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [BEAT_W-1:0] mem_wdata;
  logic [BEAT_W-1:0] mem_rdata;
  logic              mem_resp;

  modport slave (
    input  addr, read, write, wdata, mem_rdata, mem_resp,
    output rdata, resp, mem_addr, mem_read, mem_write, mem_wdata
  );

  modport master (
    output addr, read, write, wdata, mem_rdata, mem_resp,
    input  rdata, resp, mem_addr, mem_read, mem_write, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/cacheline_adapter.sv
`default_nettype none
// ============================================================================
// Module      : cacheline_adapter
// Description : Converts one LINE_W-bit cacheline request into a burst of
//               BEAT_W-bit beats on the memory port, and back again. Only one
//               request is outstanding at a time. Read beats are gathered
//               into a line buffer. A latched write line is sent out beat by
//               beat. Completion is signalled with a one-cycle resp pulse.
// Ports       :
//   clk   in  clock, rising edge
//   rst   in  asynchronous active-low reset
//   bus   slave modport of cacheline_adapter_if (arbiter + memory signals)
// Revision    : 1.0 - initial release
// ============================================================================
module cacheline_adapter #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  wire logic               clk,
  input  wire logic               rst,
  cacheline_adapter_if.slave      bus
);

  // BEATS must be a power of two, >= 2, so the counter wraps naturally
  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // Byte-offset bits within a line are cleared to form the burst base
  localparam logic [31:0] ADDR_OFFS_MASK = 32'(LINE_W / 8 - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [BEATS-1:0][BEAT_W-1:0]   linebuf_q;
  logic [BEATS-1:0][BEAT_W-1:0]   wbuf_q;
  logic [31:0]                    mem_addr_q;

  // --------------------------------------------------------------------------
  // State and counter register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. The counter wraps to 0 on the last beat, so leaving a
  // burst needs no separate clear.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        // A write wins over a simultaneous (illegal) read
        if (bus.write) begin
          state_d = S_WRITE;
          cnt_d   = '0;
        end else if (bus.read) begin
          state_d = S_READ;
          cnt_d   = '0;
        end
      end
      S_READ, S_WRITE: begin
        if (bus.mem_resp) begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers: burst address, write line buffer, read line buffer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr_q <= '0;
      wbuf_q     <= '0;
      linebuf_q  <= '0;
    end else begin
      if (state_q == S_IDLE) begin
        if (bus.write) begin
          mem_addr_q <= bus.addr & ~ADDR_OFFS_MASK;
          wbuf_q     <= bus.wdata;
        end else if (bus.read) begin
          mem_addr_q <= bus.addr & ~ADDR_OFFS_MASK;
        end
      end
      if (state_q == S_READ && bus.mem_resp) begin
        linebuf_q[cnt_q] <= bus.mem_rdata;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. These decode from registers only, so no input reaches an output
  // combinationally.
  // --------------------------------------------------------------------------
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_read  = (state_q == S_READ);
  assign bus.mem_write = (state_q == S_WRITE);
  assign bus.mem_wdata = (state_q == S_WRITE) ? wbuf_q[cnt_q] : '0;
  assign bus.resp      = (state_q == S_RESP);
  assign bus.rdata     = linebuf_q;

endmodule
`default_nettype wire

// File: tb/tb_cacheline_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cacheline_adapter
// Description : Directed self-checking bench for cacheline_adapter. It covers
//               reset, reads with and without stalls, writes, simultaneous
//               read/write, and an asynchronous reset in the middle of a
//               burst.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cacheline_adapter;

  logic clk;
  logic rst;
  int   n_total = 0;
  int   n_bad   = 0;

  cacheline_adapter_if #(.LINE_W(256), .BEAT_W(64)) bus ();

  cacheline_adapter #(.LINE_W(256), .BEAT_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Inputs are driven and outputs sampled on the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Read burst. Bit i of pat gives mem_resp in burst cycle i. Beats are
  // supplied in order on the cycles where pat is 1.
  task automatic run_read(input string tag, input logic [31:0] a, input logic [31:0] exp_addr,
                          input logic [3:0][63:0] beats, input logic [15:0] pat, input int plen);
    int k;
    k = 0;
    bus.addr  = a;
    bus.read  = 1'b1;
    bus.write = 1'b0;
    step();
    bus.addr  = 32'hFFFF_FFFF;  // a change after acceptance must not matter
    for (int i = 0; i < plen; i++) begin
      check({tag, ".mem_read"},  bus.mem_read,  1'b1);
      check({tag, ".mem_write"}, bus.mem_write, 1'b0);
      check({tag, ".mem_addr"},  bus.mem_addr,  exp_addr);
      check({tag, ".resp_early"}, bus.resp,     1'b0);
      bus.mem_resp  = pat[i];
      bus.mem_rdata = pat[i] ? beats[k] : 64'hDEAD_BEEF_DEAD_BEEF;
      if (pat[i]) k++;
      step();
    end
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = '0;
    check({tag, ".resp"},         bus.resp,     1'b1);
    check({tag, ".mem_read_off"}, bus.mem_read, 1'b0);
    check({tag, ".rdata"},        bus.rdata,    beats);
    bus.read = 1'b0;
    step();
    check({tag, ".resp_single"}, bus.resp,     1'b0);
    check({tag, ".idle_read"},   bus.mem_read, 1'b0);
  endtask

  // Write burst with mem_resp high every cycle. also_read raises read too.
  task automatic run_write(input string tag, input logic [31:0] a, input logic [31:0] exp_addr,
                           input logic [3:0][63:0] wd, input logic also_read);
    bus.addr  = a;
    bus.wdata = wd;
    bus.write = 1'b1;
    bus.read  = also_read;
    step();
    for (int i = 0; i < 4; i++) begin
      check({tag, ".mem_write"}, bus.mem_write, 1'b1);
      check({tag, ".mem_read"},  bus.mem_read,  1'b0);
      check({tag, ".mem_addr"},  bus.mem_addr,  exp_addr);
      check({tag, ".mem_wdata"}, bus.mem_wdata, wd[i]);
      check({tag, ".resp_early"}, bus.resp,     1'b0);
      bus.mem_resp = 1'b1;
      if (i == 1) bus.wdata = {4{64'h0BAD_0BAD_0BAD_0BAD}};
      step();
    end
    bus.mem_resp = 1'b0;
    check({tag, ".resp"},          bus.resp,      1'b1);
    check({tag, ".mem_write_off"}, bus.mem_write, 1'b0);
    check({tag, ".mem_read_off"},  bus.mem_read,  1'b0);
    bus.write = 1'b0;
    bus.read  = 1'b0;
    step();
    check({tag, ".resp_single"}, bus.resp,      1'b0);
    check({tag, ".idle_write"},  bus.mem_write, 1'b0);
    check({tag, ".idle_read"},   bus.mem_read,  1'b0);
  endtask

  initial begin
    // ---------------- Reset with random inputs ----------------
    rst = 1'b0;
    @(negedge clk);
    bus.addr      = $urandom;
    bus.read      = 1'b1;
    bus.write     = 1'b1;
    bus.wdata     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    bus.mem_rdata = {$urandom, $urandom};
    bus.mem_resp  = 1'b1;
    repeat (3) step();
    check("rst.resp",      bus.resp,      1'b0);
    check("rst.rdata",     bus.rdata,     256'h0);
    check("rst.mem_addr",  bus.mem_addr,  32'h0);
    check("rst.mem_read",  bus.mem_read,  1'b0);
    check("rst.mem_write", bus.mem_write, 1'b0);
    check("rst.mem_wdata", bus.mem_wdata, 64'h0);

    // Release; a stray mem_resp with no request must do nothing
    bus.read      = 1'b0;
    bus.write     = 1'b0;
    bus.addr      = '0;
    bus.wdata     = '0;
    bus.mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle.resp",      bus.resp,      1'b0);
      check("idle.mem_read",  bus.mem_read,  1'b0);
      check("idle.mem_write", bus.mem_write, 1'b0);
    end
    check("idle.rdata", bus.rdata, 256'h0);
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = '0;

    // ---------------- Read, back-to-back beats ----------------
    run_read("rd_b2b", 32'h1234_5678, 32'h1234_5660,
             {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
             16'h000F, 4);

    // ---------------- Read with stalls 1,0,0,1,1,0,1 ----------------
    run_read("rd_stall", 32'h0000_ABCD, 32'h0000_ABC0,
             {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
              64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555},
             16'h0059, 7);

    // ---------------- Write ----------------
    run_write("wr", 32'h0000_0100, 32'h0000_0100,
              {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
               64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, 1'b0);

    // ---------------- Simultaneous read+write ----------------
    run_write("rdwr", 32'h0000_0040, 32'h0000_0040,
              {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
               64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101}, 1'b1);

    // ---------------- Reset mid-read after 2 beats ----------------
    bus.addr = 32'h0000_1000;
    bus.read = 1'b1;
    step();
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 64'h9999_9999_9999_9999;
    step();
    bus.mem_rdata = 64'hAAAA_0000_AAAA_0000;
    step();
    check("mid.mem_read_before", bus.mem_read, 1'b1);
    rst = 1'b0;
    #1;
    check("mid.async_mem_read", bus.mem_read, 1'b0);
    check("mid.async_rdata",    bus.rdata,    256'h0);
    check("mid.async_mem_addr", bus.mem_addr, 32'h0);
    check("mid.async_resp",     bus.resp,     1'b0);
    bus.read      = 1'b0;
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = '0;
    step();
    check("mid.resp_in_rst", bus.resp, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("mid.resp_after",     bus.resp,     1'b0);
      check("mid.mem_read_after", bus.mem_read, 1'b0);
    end

    run_read("rd_fresh", 32'h0000_2010, 32'h0000_2000,
             {64'hF4F4_F4F4_F4F4_F4F4, 64'hF3F3_F3F3_F3F3_F3F3,
              64'hF2F2_F2F2_F2F2_F2F2, 64'hF1F1_F1F1_F1F1_F1F1},
             16'h000F, 4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
